intc_ctrl: RTL and testbench

- Memory-mapped interrupt controller that drives the single-cycle CPU's `intr` input and consumes its `inta` acknowledge.
- Latches up to NSRC external interrupt sources and applies a software mask.
- Selects the highest-priority request, raises `intr`, and captures the vector on `inta`.
- Holds off further requests until software writes end-of-interrupt (EOI) through the data bus (Daddr/Dwrite/Wmem path).

---
 rtl/intc_ctrl.sv | 141 ++++++++++++++
 tb/tb_intc_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/intc_ctrl.sv
// rtl/intc_ctrl.sv - memory-mapped interrupt controller: edge latch, mask, priority select, inta/EOI handshake
// Optional level-triggered sources enabled by defining INTC_LEVEL_TRIG_EN.
module intc_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h00000F00
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic [NSRC-1:0] src,
    input  logic [31:0]     Addr,
    input  logic [31:0]     Wdata,
    input  logic            We,
    output logic [31:0]     Rdata,
    output logic            Sel,
    output logic            intr,
    input  logic            inta,
    output logic [4:0]      vec
);

`ifdef INTC_LEVEL_TRIG_EN
    localparam logic [31:0] WIN_BYTES = 32'd20;
`else
    localparam logic [31:0] WIN_BYTES = 32'd16;
`endif

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] src_prev_q;
    logic [4:0]      vec_q, vec_d;
    logic [NSRC-1:0] req, set_edge, w1c, ack_clr, pend_edge;
    logic            req_any;
    logic [3:0]      idx;
    logic [31:0]     off;
    logic [2:0]      word;
    logic            wr_pend, wr_mask, wr_eoi;
    logic            unused_bits;

    // Offset wraps for addresses below the base, so a single compare covers both bounds.
    assign off  = Addr - BASE_ADDR;
    assign Sel  = (off < WIN_BYTES);
    assign word = off[4:2];
    assign unused_bits = ^{off[31:5], off[1:0], Wdata};

    assign wr_pend = We & Sel & (word == 3'd0);
    assign wr_mask = We & Sel & (word == 3'd1);
    assign wr_eoi  = We & Sel & (word == 3'd3);

    assign req      = pend_q & mask_q;
    assign req_any  = |req;
    assign set_edge = src & ~src_prev_q;
    assign w1c      = wr_pend ? Wdata[NSRC-1:0] : '0;

    always_comb begin
        idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_clr = '0;
        case (state_q)
            IDLE: if (req_any) state_d = REQ;
            REQ: begin
                if (inta) begin
                    vec_d   = {1'b1, idx};
                    ack_clr = req_any ? (NSRC'(1) << idx) : '0;
                    state_d = SERV;
                end else if (!req_any) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (wr_eoi) begin
                    vec_d   = 5'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge outranks both software W1C and the acknowledge clear.
    assign pend_edge = (pend_q & ~w1c & ~ack_clr) | set_edge;
    assign mask_d    = wr_mask ? Wdata[NSRC-1:0] : mask_q;

`ifdef INTC_LEVEL_TRIG_EN
    logic [NSRC-1:0] trig_q, trig_d;
    logic            wr_trig;

    assign wr_trig = We & Sel & (word == 3'd4);
    assign trig_d  = wr_trig ? Wdata[NSRC-1:0] : trig_q;
    assign pend_d  = (pend_edge & ~trig_q) | (src & trig_q);

    always_ff @(posedge Clk) begin
        if (Clrn) trig_q <= '0;
        else      trig_q <= trig_d;
    end
`else
    assign pend_d = pend_edge;
`endif

    always_ff @(posedge Clk) begin
        src_prev_q <= src;
        if (Clrn) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            vec_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
        end
    end

    assign intr = (state_q == REQ);
    assign vec  = vec_q;

    always_comb begin
        Rdata = 32'd0;
        if (Sel) begin
            case (word)
                3'd0: Rdata = {{(32-NSRC){1'b0}}, pend_q};
                3'd1: Rdata = {{(32-NSRC){1'b0}}, mask_q};
                3'd2: Rdata = {27'd0, vec_q};
`ifdef INTC_LEVEL_TRIG_EN
                3'd4: Rdata = {{(32-NSRC){1'b0}}, trig_q};
`endif
                default: Rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_ctrl.sv
// tb/tb_intc_ctrl.sv - scoreboard bench for intc_ctrl
module tb_intc_ctrl;

    localparam int          NSRC = 8;
    localparam logic [31:0] BASE = 32'h00000F00;
    localparam logic [31:0] A_PEND = BASE + 32'h0;
    localparam logic [31:0] A_MASK = BASE + 32'h4;
    localparam logic [31:0] A_VEC  = BASE + 32'h8;
    localparam logic [31:0] A_EOI  = BASE + 32'hC;

    logic            Clk = 1'b0;
    logic            Clrn = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic [31:0]     Addr = '0;
    logic [31:0]     Wdata = '0;
    logic            We = 1'b0;
    logic [31:0]     Rdata;
    logic            Sel;
    logic            intr;
    logic            inta = 1'b0;
    logic [4:0]      vec;

    int checks = 0;
    int failures = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    intc_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Clrn(Clrn), .src(src), .Addr(Addr), .Wdata(Wdata), .We(We),
        .Rdata(Rdata), .Sel(Sel), .intr(intr), .inta(inta), .vec(vec)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic observe(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        We = 1'b0;
        #1;
        d = Rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        Wdata = d;
        We = 1'b1;
        tick();
        We = 1'b0;
    endtask

    task automatic do_ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        // Reset state
        tick(); tick();
        Clrn = 1'b0;
        expect_val("rst_intr", 0); expect_val("rst_vec", 0);
        expect_val("rst_pend", 0); expect_val("rst_mask", 0);
        observe(32'(intr)); observe(32'(vec));
        rd(A_PEND, r); observe(r);
        rd(A_MASK, r); observe(r);

        // Window decode
        expect_val("sel_eoi", 1); expect_val("sel_past_end", 0); expect_val("sel_below", 0);
        Addr = A_EOI; #1; observe(32'(Sel));
        Addr = BASE + 32'h10; #1; observe(32'(Sel));
        Addr = BASE - 32'h1; #1; observe(32'(Sel));

        // Single source, latency and acknowledge
        wr(A_MASK, 32'h01);
        expect_val("t1_intr_k", 0); expect_val("t1_intr_k1", 1);
        src = 8'h01; tick(); src = 8'h00;
        observe(32'(intr));
        tick(); observe(32'(intr));
        expect_val("t1_vec", 5'b10000); expect_val("t1_pend", 0);
        expect_val("t1_intr_serv", 0); expect_val("t1_vec_reg", 32'h10);
        do_ack();
        observe(32'(vec));
        rd(A_PEND, r); observe(r);
        observe(32'(intr));
        rd(A_VEC, r); observe(r);
        expect_val("t1_inta_serv_ignored", 5'b10000);
        do_ack(); observe(32'(vec));
        expect_val("t1_eoi_vec", 0);
        wr(A_EOI, 32'h0); observe(32'(vec));

        // Two simultaneous sources, priority order
        wr(A_MASK, 32'hFF);
        expect_val("t2_intr", 1); expect_val("t2_vec_a", 5'b10010); expect_val("t2_pend_a", 32'h20);
        src = 8'h24; tick(); src = 8'h00; tick();
        observe(32'(intr));
        do_ack(); observe(32'(vec));
        rd(A_PEND, r); observe(r);
        expect_val("t2_eoi_intr", 0); expect_val("t2_reassert", 1);
        expect_val("t2_vec_b", 5'b10101); expect_val("t2_pend_b", 0);
        wr(A_EOI, 32'h0); observe(32'(intr));
        tick(); observe(32'(intr));
        do_ack(); observe(32'(vec));
        rd(A_PEND, r); observe(r);
        wr(A_EOI, 32'h0);

        // Masked pending, then unmask (old mask used on the write edge)
        wr(A_MASK, 32'h00);
        expect_val("t3_pend", 32'h08); expect_val("t3_intr_masked", 0);
        expect_val("t3_intr_wredge", 0); expect_val("t3_intr_unmasked", 1);
        src = 8'h08; tick(); src = 8'h00; tick();
        rd(A_PEND, r); observe(r);
        observe(32'(intr));
        wr(A_MASK, 32'h08); observe(32'(intr));
        tick(); observe(32'(intr));
        expect_val("t3_vec", 5'b10011);
        do_ack(); observe(32'(vec));

        // Reset during service
        expect_val("t6_vec", 0); expect_val("t6_intr", 0);
        expect_val("t6_mask", 0); expect_val("t6_pend", 0);
        Clrn = 1'b1; tick(); Clrn = 1'b0;
        observe(32'(vec)); observe(32'(intr));
        rd(A_MASK, r); observe(r);
        rd(A_PEND, r); observe(r);

        // Source high through reset release, then set beats W1C
        expect_val("t5_no_edge", 0); expect_val("t5_set_wins", 32'h10);
        src = 8'h10; Clrn = 1'b1; tick(); tick(); Clrn = 1'b0; tick(); tick();
        rd(A_PEND, r); observe(r);
        src = 8'h00; tick();
        src = 8'h10; wr(A_PEND, 32'h10);
        rd(A_PEND, r); observe(r);
        src = 8'h00; wr(A_PEND, 32'h10);

        // W1C while requesting withdraws the request
        wr(A_MASK, 32'h02);
        expect_val("t4_req", 1); expect_val("t4_req_hold", 1);
        expect_val("t4_idle", 0); expect_val("t4_pend", 0); expect_val("t4_vec", 0);
        expect_val("t4_intr_after_inta", 0);
        src = 8'h02; tick(); src = 8'h00; tick();
        observe(32'(intr));
        wr(A_PEND, 32'h02); observe(32'(intr));
        tick(); observe(32'(intr));
        rd(A_PEND, r); observe(r);
        do_ack(); observe(32'(vec));
        observe(32'(intr));

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
